// File: rtl/keynsham_irq_ctrl_pkg.sv
// keynsham_irq_ctrl_pkg: register map, claim layout and byte-lane helper
// shared by the keynsham interrupt controller files.
package keynsham_irq_ctrl_pkg;

  // Word offsets within the controller window, selected by bus_addr[2:0].
  localparam logic [2:0] IRQ_REG_STATUS   = 3'd0;
  localparam logic [2:0] IRQ_REG_ENABLE   = 3'd1;
  localparam logic [2:0] IRQ_REG_PENDING  = 3'd2;
  localparam logic [2:0] IRQ_REG_EDGE_CFG = 3'd3;
  localparam logic [2:0] IRQ_REG_CLAIM    = 3'd4;
  localparam logic [2:0] IRQ_REG_SWTRIG   = 3'd5;

  // CLAIM read layout: valid flag in the top bit, line index in the bottom bits.
  localparam int CLAIM_VALID_BIT = 31;
  localparam int IRQ_ID_W        = 5;

  // Expand the four byte enables into a 32-bit write mask.
  function automatic logic [31:0] lane_mask(input logic [3:0] bytesel);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[b*8 +: 8] = {8{bytesel[b]}};
    return m;
  endfunction

endpackage

// File: rtl/cs_gen.sv
// cs_gen: chip select for a byte-addressed window [bus_address, bus_address+bus_size)
// decoded from a 30-bit word address.
module cs_gen #(
  parameter logic [31:0] bus_address = 32'h0,
  parameter logic [31:0] bus_size    = 32'h0
) (
  input  logic [29:0] bus_addr,
  output logic        bus_cs
);

  logic [32:0] byte_addr;
  logic [32:0] lo;
  logic [32:0] hi;

  // One extra bit keeps the window end from wrapping at the top of memory.
  assign byte_addr = {1'b0, bus_addr, 2'b00};
  assign lo        = {1'b0, bus_address};
  assign hi        = lo + {1'b0, bus_size};
  assign bus_cs    = (byte_addr >= lo) && (byte_addr < hi);

endmodule

// File: rtl/keynsham_prio_enc.sv
// keynsham_prio_enc: combinational lowest-index-first priority encoder.
module keynsham_prio_enc
  import keynsham_irq_ctrl_pkg::*;
#(
  parameter int width = 32
) (
  input  logic [width-1:0]    req,
  output logic                valid,
  output logic [IRQ_ID_W-1:0] id
);

  // Scan from the top down so the last hit, the lowest index, is what remains.
  always_comb begin
    // NOTE: outputs get a default before any condition, so no path can leave them unassigned and infer a latch.
    valid = 1'b0;
    id    = '0;
    for (int i = width - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        id    = IRQ_ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/keynsham_irq_ctrl.sv
// keynsham_irq_ctrl: memory-mapped interrupt controller. Latches edge-mode
// lines, passes level-mode lines, masks with ENABLE, offers a lowest-index
// CLAIM register and drives a registered irq_out to the CPU.
// Optional feature: define KEYNSHAM_IRQ_SWTRIG_EN to build the write-only
// SWTRIG register at offset 5; otherwise offset 5 is unmapped.
module keynsham_irq_ctrl
  import keynsham_irq_ctrl_pkg::*;
#(
  parameter logic [31:0] bus_address = 32'h0,
  parameter logic [31:0] bus_size    = 32'h0,
  parameter int          nr_irqs     = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               bus_access,
  output logic               bus_cs,
  input  logic [29:0]        bus_addr,
  input  logic [31:0]        bus_wr_val,
  input  logic               bus_wr_en,
  input  logic [3:0]         bus_bytesel,
  output logic               bus_error,
  output logic               bus_ack,
  output logic [31:0]        bus_data,
  input  logic [nr_irqs-1:0] irqs_in,
  output logic               irq_out
);

  logic [nr_irqs-1:0] enable, edge_cfg, latch, prev;
  logic [nr_irqs-1:0] pending, pend_en, lane, wr_bits;
  logic [nr_irqs-1:0] edge_set, set_bits, clr_bits, claim_clr;
  logic [nr_irqs-1:0] edge_next, latch_next;
  logic [31:0]        lane32, rdata;
  logic [2:0]         reg_sel;
  logic               acc, err, go;
  logic               we_enable, we_pending, we_edge, claim_rd;
  logic               claim_valid;
  logic [IRQ_ID_W-1:0] claim_id;
`ifdef KEYNSHAM_IRQ_SWTRIG_EN
  logic               we_swtrig;
`endif

  cs_gen #(
    .bus_address(bus_address),
    .bus_size   (bus_size)
  ) u_cs_gen (
    .bus_addr(bus_addr),
    .bus_cs  (bus_cs)
  );

  // Level lines follow the input live; edge lines show their latch.
  assign pending  = (latch & edge_cfg) | (irqs_in & ~edge_cfg);
  assign pend_en  = pending & enable;
  assign edge_set = irqs_in & ~prev & edge_cfg;

  assign lane32  = lane_mask(bus_bytesel);
  assign lane    = lane32[nr_irqs-1:0];
  assign wr_bits = bus_wr_val[nr_irqs-1:0] & lane;
  assign reg_sel = bus_addr[2:0];
  assign acc     = bus_access & bus_cs;
  assign go      = acc & ~err;

  keynsham_prio_enc #(
    .width(nr_irqs)
  ) u_prio_enc (
    .req  (pend_en),
    .valid(claim_valid),
    .id   (claim_id)
  );

  // Register decode: read data, write strobes and unmapped/read-only errors.
  always_comb begin
    err        = 1'b0;
    rdata      = '0;
    we_enable  = 1'b0;
    we_pending = 1'b0;
    we_edge    = 1'b0;
    claim_rd   = 1'b0;
`ifdef KEYNSHAM_IRQ_SWTRIG_EN
    we_swtrig  = 1'b0;
`endif
    case (reg_sel)
      IRQ_REG_STATUS:   if (bus_wr_en) err = 1'b1; else rdata = 32'(pend_en);
      IRQ_REG_ENABLE:   if (bus_wr_en) we_enable = 1'b1; else rdata = 32'(enable);
      IRQ_REG_PENDING:  if (bus_wr_en) we_pending = 1'b1; else rdata = 32'(pending);
      IRQ_REG_EDGE_CFG: if (bus_wr_en) we_edge = 1'b1; else rdata = 32'(edge_cfg);
      IRQ_REG_CLAIM: begin
        if (bus_wr_en) begin
          err = 1'b1;
        end else begin
          claim_rd = 1'b1;
          if (claim_valid) begin
            rdata[CLAIM_VALID_BIT]  = 1'b1;
            rdata[IRQ_ID_W-1:0]     = claim_id;
          end
        end
      end
`ifdef KEYNSHAM_IRQ_SWTRIG_EN
      IRQ_REG_SWTRIG:   if (bus_wr_en) we_swtrig = 1'b1; else err = 1'b1;
`endif
      default:          err = 1'b1;
    endcase
  end

  // One-hot clear of the line a CLAIM read hands out.
  always_comb begin
    claim_clr = '0;
    for (int i = 0; i < nr_irqs; i++)
      claim_clr[i] = go && claim_rd && claim_valid && (claim_id == IRQ_ID_W'(i));
  end

  // Next edge configuration and latch state; a new edge beats any clear.
  always_comb begin
    edge_next = edge_cfg;
    if (go && we_edge) edge_next = (edge_cfg & ~lane) | wr_bits;
    clr_bits = claim_clr;
    if (go && we_pending) clr_bits = clr_bits | wr_bits;
    set_bits = edge_set;
`ifdef KEYNSHAM_IRQ_SWTRIG_EN
    if (go && we_swtrig) set_bits = set_bits | wr_bits;
`endif
    // Masking with both old and new config drops latches on edge->level
    // and keeps level->edge lines starting from zero.
    latch_next = ((latch & ~clr_bits) | set_bits) & edge_cfg & edge_next;
  end

  // Bus response, interrupt output and register state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_ack   <= 1'b0;
      bus_error <= 1'b0;
      bus_data  <= '0;
      irq_out   <= 1'b0;
      enable    <= '0;
      edge_cfg  <= '0;
      latch     <= '0;
      prev      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values, as the flops do.
      bus_ack   <= go;
      bus_error <= acc & err;
      bus_data  <= go ? rdata : '0;
      irq_out   <= |pend_en;
      prev      <= irqs_in;
      edge_cfg  <= edge_next;
      latch     <= latch_next;
      if (go && we_enable) enable <= (enable & ~lane) | wr_bits;
    end
  end

endmodule
